// File: rtl/matrix_calculator_p.sv
// ---------------------------------------------------------------------------
// matrix_calculator_p
// Holds one resident N x N matrix M (W-bit elements) and applies host
// commands to it: LOAD, MUL (M <= A x M), ADD, TRANSPOSE, CLEAR and READ.
// Multiply produces one result row per cycle into a shadow buffer and commits
// the whole buffer to M in one edge, so M never shows a half-updated product.
//
// Ports
//   CLK         in   rising-edge clock
//   reset       in   asynchronous, active-low; clears all state
//   cmd_valid   in   command / Matrix_in valid
//   cmd_ready   out  high while IDLE (registered)
//   command     in   opcode 0 NOP,1 LOAD,2 MUL,3 ADD,4 TRANSPOSE,5 READ,6 CLEAR
//   Matrix_in   in   operand; element (r,c) at [(r*N+c)*W +: W]
//   Matrix_out  out  resident matrix M, same packing
//   out_valid   out  READ result presented, held until out_ready
//   out_ready   in   consumer takes the READ result
//   done        out  one-cycle pulse when a MUL commits
//   state       out  0 IDLE, 1 CALC, 2 OUT
// ---------------------------------------------------------------------------
module matrix_calculator_p #(
   parameter int N = 4,
   parameter int W = 32
) (
   input  logic                 CLK,
   input  logic                 reset,
   input  logic                 cmd_valid,
   output logic                 cmd_ready,
   input  logic [3:0]           command,
   input  logic [N*N*W-1:0]     Matrix_in,
   output logic [N*N*W-1:0]     Matrix_out,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 done,
   output logic [1:0]           state
);

   localparam int MW = N * N * W;
   localparam int KW = $clog2(N);

   localparam logic [3:0] OP_LOAD      = 4'd1;
   localparam logic [3:0] OP_MUL       = 4'd2;
   localparam logic [3:0] OP_ADD       = 4'd3;
   localparam logic [3:0] OP_TRANSPOSE = 4'd4;
   localparam logic [3:0] OP_READ      = 4'd5;
   localparam logic [3:0] OP_CLEAR     = 4'd6;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_OUT  = 2'd2,
      ST_RSVD = 2'd3
   } state_t;

   state_t            state_q,     state_d;
   logic [MW-1:0]     m_q,         m_d;
   logic [MW-1:0]     a_q,         a_d;
   logic [MW-1:0]     shadow_q,    shadow_d;
   logic [KW-1:0]     k_q,         k_d;
   logic              out_valid_q, out_valid_d;
   logic              done_q,      done_d;
   logic              cmd_ready_q, cmd_ready_d;

   // One product row: row_s[c] = sum_j A[k][j] * M[j][c], wrapping mod 2^W.
   logic [N-1:0][W-1:0] row_s;

   // Combinational dot products for the row selected by the row counter.
   always_comb begin
      row_s = '0;
      for (int c = 0; c < N; c++) begin
         for (int j = 0; j < N; j++) begin
            row_s[c] = row_s[c] +
                       (a_q[(int'(k_q) * N + j) * W +: W] * m_q[(j * N + c) * W +: W]);
         end
      end
   end

   // Next-state logic for the FSM, resident matrix and handshake outputs.
   always_comb begin
      state_d     = state_q;
      m_d         = m_q;
      a_d         = a_q;
      shadow_d    = shadow_q;
      k_d         = k_q;
      out_valid_d = out_valid_q;
      done_d      = 1'b0;

      case (state_q)
         ST_IDLE: begin
            out_valid_d = 1'b0;
            if (cmd_valid) begin
               case (command)
                  OP_LOAD: begin
                     m_d = Matrix_in;
                  end
                  OP_ADD: begin
                     for (int i = 0; i < N * N; i++) begin
                        m_d[i * W +: W] = m_q[i * W +: W] + Matrix_in[i * W +: W];
                     end
                  end
                  OP_TRANSPOSE: begin
                     for (int r = 0; r < N; r++) begin
                        for (int c = 0; c < N; c++) begin
                           m_d[(r * N + c) * W +: W] = m_q[(c * N + r) * W +: W];
                        end
                     end
                  end
                  OP_CLEAR: begin
                     m_d = '0;
                  end
                  OP_MUL: begin
                     a_d     = Matrix_in;
                     k_d     = '0;
                     state_d = ST_CALC;
                  end
                  OP_READ: begin
                     out_valid_d = 1'b1;
                     state_d     = ST_OUT;
                  end
                  default: begin
                     // NOP and undefined opcodes: accepted, no effect
                     m_d = m_q;
                  end
               endcase
            end else begin
               state_d = ST_IDLE;
            end
         end

         ST_CALC: begin
            shadow_d[int'(k_q) * N * W +: N * W] = row_s;
            if (k_q == KW'(N - 1)) begin
               // shadow_d already carries the last row, so commit it whole
               m_d     = shadow_d;
               done_d  = 1'b1;
               k_d     = '0;
               state_d = ST_IDLE;
            end else begin
               k_d = k_q + KW'(1);
            end
         end

         ST_OUT: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = ST_IDLE;
            end else begin
               out_valid_d = 1'b1;
            end
         end

         default: begin
            out_valid_d = 1'b0;
            state_d     = ST_IDLE;
         end
      endcase

      cmd_ready_d = (state_d == ST_IDLE);
   end

   // State and datapath registers with asynchronous active-low reset.
   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         m_q         <= '0;
         a_q         <= '0;
         shadow_q    <= '0;
         k_q         <= '0;
         out_valid_q <= 1'b0;
         done_q      <= 1'b0;
         cmd_ready_q <= 1'b1;
      end else begin
         state_q     <= state_d;
         m_q         <= m_d;
         a_q         <= a_d;
         shadow_q    <= shadow_d;
         k_q         <= k_d;
         out_valid_q <= out_valid_d;
         done_q      <= done_d;
         cmd_ready_q <= cmd_ready_d;
      end
   end

   assign cmd_ready  = cmd_ready_q;
   assign Matrix_out = m_q;
   assign out_valid  = out_valid_q;
   assign done       = done_q;
   assign state      = state_q;

endmodule

// File: tb/tb_matrix_calculator_p.sv
// Directed bench for matrix_calculator_p: one N=4/W=32 instance and one
// N=2/W=32 instance, hand-computed expected matrices.
module tb_matrix_calculator_p;

   logic CLK = 1'b0;
   logic reset;
   always #5 CLK = ~CLK;

   // N=4 instance
   logic         v4, ordy4, rdy4, ov4, dn4;
   logic [3:0]   cmd4;
   logic [511:0] in4, mo4;
   logic [1:0]   st4;

   // N=2 instance
   logic         v2, ordy2, rdy2, ov2, dn2;
   logic [3:0]   cmd2;
   logic [127:0] in2, mo2;
   logic [1:0]   st2;

   int checks = 0;
   int errors = 0;

   matrix_calculator_p #(.N(4), .W(32)) u_dut4 (
      .CLK(CLK), .reset(reset), .cmd_valid(v4), .cmd_ready(rdy4),
      .command(cmd4), .Matrix_in(in4), .Matrix_out(mo4),
      .out_valid(ov4), .out_ready(ordy4), .done(dn4), .state(st4)
   );

   matrix_calculator_p #(.N(2), .W(32)) u_dut2 (
      .CLK(CLK), .reset(reset), .cmd_valid(v2), .cmd_ready(rdy2),
      .command(cmd2), .Matrix_in(in2), .Matrix_out(mo2),
      .out_valid(ov2), .out_ready(ordy2), .done(dn2), .state(st2)
   );

   task automatic check_value(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   function automatic logic [511:0] fill4(input logic [31:0] v);
      logic [511:0] r;
      for (int i = 0; i < 16; i++) r[i * 32 +: 32] = v;
      return r;
   endfunction

   function automatic logic [511:0] ident4();
      logic [511:0] r;
      r = '0;
      for (int i = 0; i < 4; i++) r[(i * 4 + i) * 32 +: 32] = 32'd1;
      return r;
   endfunction

   // element (r,c) = r*4 + c + off
   function automatic logic [511:0] seq4(input int off);
      logic [511:0] r;
      for (int i = 0; i < 16; i++) r[i * 32 +: 32] = 32'(i + off);
      return r;
   endfunction

   task automatic issue4(input logic [3:0] c, input logic [511:0] m);
      v4 = 1'b1; cmd4 = c; in4 = m;
      step();
      v4 = 1'b0;
   endtask

   task automatic issue2(input logic [3:0] c, input logic [127:0] m);
      v2 = 1'b1; cmd2 = c; in2 = m;
      step();
      v2 = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b0;
      v4 = 1'b0; cmd4 = 4'd0; in4 = '0; ordy4 = 1'b0;
      v2 = 1'b0; cmd2 = 4'd0; in2 = '0; ordy2 = 1'b0;
      repeat (3) @(posedge CLK);
      #1 reset = 1'b1;

      // reset state
      check_value("rst_mout", mo4, '0);
      check_value("rst_ovalid", 512'(ov4), 512'(1'b0));
      check_value("rst_done", 512'(dn4), 512'(1'b0));
      check_value("rst_state", 512'(st4), 512'(2'd0));
      check_value("rst_ready", 512'(rdy4), 512'(1'b1));
      check_value("rst_mout2", 512'(mo2), '0);

      // reset in the middle of a multiply
      issue4(4'd1, ident4());
      issue4(4'd2, seq4(0));   // CALC cycle 1
      step();                  // CALC cycle 2
      reset = 1'b0;
      #1;
      check_value("midmul_rst_mout", mo4, '0);
      check_value("midmul_rst_state", 512'(st4), 512'(2'd0));
      check_value("midmul_rst_done", 512'(dn4), 512'(1'b0));
      step();
      reset = 1'b1;
      for (int i = 0; i < 6; i++) begin
         step();
         check_value("midmul_no_done", 512'(dn4), 512'(1'b0));
         check_value("midmul_no_commit", mo4, '0);
      end

      // identity multiply: C = A x I = A
      issue4(4'd1, ident4());
      check_value("load_ident", mo4, ident4());
      issue4(4'd2, seq4(0));
      for (int i = 0; i < 4; i++) begin
         check_value("mul_ready_low", 512'(rdy4), 512'(1'b0));
         check_value("mul_done_low", 512'(dn4), 512'(1'b0));
         check_value("mul_m_stable", mo4, ident4());
         step();
      end
      check_value("mul_ident_result", mo4, seq4(0));
      check_value("mul_done_pulse", 512'(dn4), 512'(1'b1));
      check_value("mul_ready_back", 512'(rdy4), 512'(1'b1));
      check_value("mul_state_idle", 512'(st4), 512'(2'd0));
      step();
      check_value("mul_done_one_cycle", 512'(dn4), 512'(1'b0));

      // wrap arithmetic
      issue4(4'd1, fill4(32'hFFFF_FFFF));
      issue4(4'd3, fill4(32'd2));
      check_value("add_wrap", mo4, fill4(32'd1));
      issue4(4'd2, fill4(32'd1));
      repeat (4) step();
      check_value("mul_ones", mo4, fill4(32'd4));
      check_value("mul_ones_done", 512'(dn4), 512'(1'b1));

      // READ handshake with a command offered during OUT
      ordy4 = 1'b0;
      issue4(4'd5, '0);
      v4 = 1'b1; cmd4 = 4'd1; in4 = '0;
      for (int i = 0; i < 3; i++) begin
         check_value("read_ovalid", 512'(ov4), 512'(1'b1));
         check_value("read_ready_low", 512'(rdy4), 512'(1'b0));
         check_value("read_state_out", 512'(st4), 512'(2'd2));
         check_value("read_m_stable", mo4, fill4(32'd4));
         check_value("read_no_done", 512'(dn4), 512'(1'b0));
         step();
      end
      ordy4 = 1'b1;
      check_value("read_ovalid_4th", 512'(ov4), 512'(1'b1));
      check_value("read_ready_low_4th", 512'(rdy4), 512'(1'b0));
      step();
      v4 = 1'b0;
      ordy4 = 1'b0;
      check_value("read_ovalid_drop", 512'(ov4), 512'(1'b0));
      check_value("read_state_idle", 512'(st4), 512'(2'd0));
      check_value("read_ready_back", 512'(rdy4), 512'(1'b1));
      check_value("read_cmd_ignored", mo4, fill4(32'd4));

      // back-to-back LOAD, ADD, CLEAR, opcode 9
      v4 = 1'b1; cmd4 = 4'd1; in4 = seq4(0);
      step();
      check_value("b2b_load", mo4, seq4(0));
      check_value("b2b_ready", 512'(rdy4), 512'(1'b1));
      cmd4 = 4'd3; in4 = fill4(32'd3);
      step();
      check_value("b2b_add", mo4, seq4(3));
      cmd4 = 4'd6; in4 = seq4(0);
      step();
      check_value("b2b_clear", mo4, '0);
      cmd4 = 4'd9; in4 = seq4(7);
      step();
      v4 = 1'b0;
      check_value("b2b_nop9", mo4, '0);
      check_value("b2b_state", 512'(st4), 512'(2'd0));
      check_value("b2b_ready_end", 512'(rdy4), 512'(1'b1));

      // N=2 non-commutative product and transpose
      issue2(4'd1, {32'd4, 32'd3, 32'd2, 32'd1});
      check_value("n2_load", 512'(mo2), 512'({32'd4, 32'd3, 32'd2, 32'd1}));
      issue2(4'd2, {32'd0, 32'd1, 32'd1, 32'd0});
      check_value("n2_ready_low", 512'(rdy2), 512'(1'b0));
      step();
      check_value("n2_m_stable", 512'(mo2), 512'({32'd4, 32'd3, 32'd2, 32'd1}));
      step();
      check_value("n2_mul", 512'(mo2), 512'({32'd2, 32'd1, 32'd4, 32'd3}));
      check_value("n2_done", 512'(dn2), 512'(1'b1));
      issue2(4'd4, '0);
      check_value("n2_transpose", 512'(mo2), 512'({32'd2, 32'd4, 32'd1, 32'd3}));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
